fx68k_regs_xfer: RTL and testbench

FX68K_REGS_XFER -- requirements
Module: fx68k_regs_xfer

---
 rtl/fx68k_regs_pkg.sv | 20 ++
 rtl/fx68k_xfer_addr_ctr.sv | 52 +++++
 rtl/fx68k_regs_xfer.sv | 150 +++++++++++++++
 tb/tb_fx68k_regs_xfer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx68k_regs_pkg.sv
// Shared constants and FSM state encoding for the register-RAM transfer engine.
// The RD_SUM state exists only when FX68K_REGS_XFER_CHECK_EN is defined.
package fx68k_regs_pkg;

  localparam int FX68K_REGS_N = 32;
  localparam logic [3:0] FX68K_BYTEENA_WR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_RD_HOLD  = 3'd3,
`ifdef FX68K_REGS_XFER_CHECK_EN
    ST_RD_SUM   = 3'd4,
`endif
    ST_WR       = 3'd5,
    ST_DONE     = 3'd6
  } xfer_state_e;

endpackage

// File: rtl/fx68k_xfer_addr_ctr.sv
// Wrapping address counter with a remaining-word down-counter; last_o flags the
// final word of the loaded range (terminal count of one).
module fx68k_xfer_addr_ctr
  import fx68k_regs_pkg::*;
#(
  parameter int ADDR_W = $clog2(FX68K_REGS_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] first_i,
  input  logic [ADDR_W-1:0] last_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d, span;
  logic [ADDR_W:0]   rem_q, rem_d;

  // span wraps modulo the RAM depth, so last < first covers the 31 -> 0 rollover
  always_comb begin
    span   = last_i - first_i;
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = first_i;
      rem_d  = {1'b0, span} + REM_ONE;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_ONE;
      rem_d  = rem_q - REM_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (ena_i) begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == REM_ONE);

endmodule

// File: rtl/fx68k_regs_xfer.sv
// Register-RAM transfer engine: dumps a wrapping address range to a stream or loads
// it from a stream. Define FX68K_REGS_XFER_CHECK_EN to append an XOR checksum word.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// RD_ISSUE | present read address to the RAM
// RD_CAPT  | capture registered RAM data into out_data
// RD_HOLD  | offer out_data until the consumer takes it
// RD_SUM   | offer the XOR checksum word (checksum builds only)
// WR       | write one streamed word per enabled handshake
// DONE     | one-cycle completion pulse
module fx68k_regs_xfer
  import fx68k_regs_pkg::*;
#(
  parameter int ADDR_W = $clog2(FX68K_REGS_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] cmd_first,
  input  logic [ADDR_W-1:0] cmd_last,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              busy,
  output logic              done
);

  xfer_state_e       state_q, state_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              ctr_load, ctr_step, ctr_last;
  logic [ADDR_W-1:0] ctr_addr;
`ifdef FX68K_REGS_XFER_CHECK_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  // The accepted range lives in the counter and the direction in the state, so
  // neither can be disturbed by cmd_* activity while busy.
  fx68k_xfer_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena_i   (clk_ena),
    .load_i  (ctr_load),
    .step_i  (ctr_step),
    .first_i (cmd_first),
    .last_i  (cmd_last),
    .addr_o  (ctr_addr),
    .last_o  (ctr_last)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
`ifdef FX68K_REGS_XFER_CHECK_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ctr_load = 1'b1;
          state_d  = cmd_load ? ST_WR : ST_RD_ISSUE;
`ifdef FX68K_REGS_XFER_CHECK_EN
          checksum_d = '0;
`endif
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        out_data_d = ram_q;
        state_d    = ST_RD_HOLD;
`ifdef FX68K_REGS_XFER_CHECK_EN
        checksum_d = checksum_q ^ ram_q;
`endif
      end
      ST_RD_HOLD: begin
        if (out_ready) begin
          if (ctr_last) begin
`ifdef FX68K_REGS_XFER_CHECK_EN
            out_data_d = checksum_q;
            state_d    = ST_RD_SUM;
`else
            state_d    = ST_DONE;
`endif
          end else begin
            ctr_step = 1'b1;
            state_d  = ST_RD_ISSUE;
          end
        end
      end
`ifdef FX68K_REGS_XFER_CHECK_EN
      ST_RD_SUM: begin
        if (out_ready) state_d = ST_DONE;
      end
`endif
      ST_WR: begin
        if (in_valid) begin
          if (ctr_last) state_d = ST_DONE;
          else          ctr_step = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
`ifdef FX68K_REGS_XFER_CHECK_EN
      checksum_q <= '0;
`endif
    end else if (clk_ena) begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
`ifdef FX68K_REGS_XFER_CHECK_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
`ifdef FX68K_REGS_XFER_CHECK_EN
  assign out_valid   = (state_q == ST_RD_HOLD) || (state_q == ST_RD_SUM);
`else
  assign out_valid   = (state_q == ST_RD_HOLD);
`endif
  assign out_data    = out_data_q;
  assign in_ready    = (state_q == ST_WR) && clk_ena;
  assign ram_address = ctr_addr;
  assign ram_wren    = (state_q == ST_WR) && in_valid;
  assign ram_byteena = (state_q == ST_WR) ? FX68K_BYTEENA_WR : 4'b0000;
  assign ram_data    = (state_q == ST_WR) ? in_data : 32'h0;

endmodule

// File: tb/tb_fx68k_regs_xfer.sv
// Bench for fx68k_regs_xfer: behavioural RAM plus a reference memory image that
// predicts dump words, load writes and the optional checksum word.
module tb_fx68k_regs_xfer;

  logic        clk = 1'b0;
  logic        rst_n, clk_ena;
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [4:0]  cmd_first, cmd_last, ram_address;
  logic        ram_wren;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_data, ram_q;
  logic        out_valid, out_ready, in_valid, in_ready, busy, done;
  logic [31:0] out_data, in_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] out_q [$];
  logic [31:0] load_data [$];

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  wr_t wr_log [$];

  always #5 clk = ~clk;

  fx68k_regs_xfer dut (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_first(cmd_first), .cmd_last(cmd_last),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_data(ram_data), .ram_q(ram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Synchronous RAM with registered read, byte enables and the same clock enable.
  always @(posedge clk) begin
    if (clk_ena) begin
      ram_q <= mem[ram_address];
      if (ram_wren) begin
        logic [31:0] w;
        w = mem[ram_address];
        for (int b = 0; b < 4; b++)
          if (ram_byteena[b]) w[b*8 +: 8] = ram_data[b*8 +: 8];
        mem[ram_address] <= w;
        wr_log.push_back('{a: ram_address, d: ram_data, be: ram_byteena});
      end
    end
  end

  // Stream monitor: records accepted words, checks an offered word never changes.
  logic [31:0] prev_data;
  bit prev_valid, prev_hs;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs && out_valid) check("hold_stable", out_data, prev_data);
      prev_hs = clk_ena && out_valid && out_ready;
      if (prev_hs) out_q.push_back(out_data);
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  // ena_mode: 0 = always enabled, 1 = alternate 1/0, 2 = random 60 %
  task automatic run_xfer(input bit load, input logic [4:0] first, input logic [4:0] last,
                          input int ena_mode, input int rdy_pct, input bit poke);
    logic [4:0]  span, a;
    logic [31:0] exp_q [$];
    logic [31:0] x;
    int n, idx, done_cnt, cyc;
    bit acc, poke_seen;
    span = last - first;
    n = int'(span) + 1;
    out_q.delete();
    wr_log.delete();
    cmd_load = load; cmd_first = first; cmd_last = last; cmd_valid = 1'b1;
    acc = 0; poke_seen = 0; idx = 0; done_cnt = 0;
    for (cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      case (ena_mode)
        0:       clk_ena = 1'b1;
        1:       clk_ena = (cyc % 2 == 0);
        default: clk_ena = ($urandom_range(0, 99) < 60);
      endcase
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = load && (idx < n) && ($urandom_range(0, 99) < rdy_pct);
      in_data   = (load && idx < n) ? load_data[idx] : $urandom;
      @(negedge clk);
      if (poke && acc && busy && !poke_seen) begin
        check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        poke_seen = 1;
      end
      if (cmd_valid && cmd_ready && clk_ena) acc = 1;
      if (in_valid && in_ready) idx++;
      if (done && clk_ena) done_cnt++;
      @(posedge clk); #1;
      if (acc) begin
        if (poke) begin
          cmd_first = 5'($urandom);
          cmd_last  = 5'd31;
          cmd_load  = ~load;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0; in_valid = 1'b0; clk_ena = 1'b1;
    check("done_pulse", done_cnt, 1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    if (load) begin
      check("wr_count", 32'(wr_log.size()), n);
      check("load_no_out", 32'(out_q.size()), 32'd0);
      for (int i = 0; i < n; i++) begin
        a = first + 5'(i);
        if (i < wr_log.size()) begin
          check("wr_addr", 32'(wr_log[i].a), 32'(a));
          check("wr_data", wr_log[i].d, load_data[i]);
          check("wr_be", 32'(wr_log[i].be), 32'h7);
        end
        ref_mem[a] = {ref_mem[a][31:24], load_data[i][23:0]};
      end
    end else begin
      x = 32'h0;
      for (int i = 0; i < n; i++) begin
        a = first + 5'(i);
        exp_q.push_back(ref_mem[a]);
        x ^= ref_mem[a];
      end
`ifdef FX68K_REGS_XFER_CHECK_EN
      exp_q.push_back(x);
`endif
      check("out_count", 32'(out_q.size()), 32'(exp_q.size()));
      check("dump_no_wr", 32'(wr_log.size()), 32'd0);
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
        check("out_word", out_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int idx, f, l;
    bit acc;
    rst_n = 1'b0; clk_ena = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
    cmd_first = '0; cmd_last = '0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 32; k++) begin
      mem[k]     = 32'h0000_0100 * k;
      ref_mem[k] = 32'h0000_0100 * k;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_byteena", 32'(ram_byteena), 32'd0);
    check("rst_address", 32'(ram_address), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_xfer(0, 5'd3, 5'd5, 0, 100, 0);
    load_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_xfer(1, 5'd30, 5'd1, 0, 100, 0);
    run_xfer(0, 5'd30, 5'd1, 0, 100, 0);
    run_xfer(0, 5'd0, 5'd9, 1, 100, 0);
    mem[7] = 32'h1234_5678;
    ref_mem[7] = 32'h1234_5678;
    run_xfer(0, 5'd7, 5'd7, 0, 100, 0);
    run_xfer(0, 5'd12, 5'd20, 2, 70, 1);
    run_xfer(0, 5'd5, 5'd4, 2, 80, 0);

    // Reset in the middle of a load with a third write pending.
    load_data = '{32'hB0B0_0010, 32'hB0B0_0011, 32'hB0B0_0012, 32'hB0B0_0013};
    wr_log.delete();
    cmd_load = 1'b1; cmd_first = 5'd10; cmd_last = 5'd13; cmd_valid = 1'b1;
    clk_ena = 1'b1; in_valid = 1'b1; in_data = load_data[0];
    idx = 0; acc = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (wr_log.size() >= 2) break;
      if (cmd_valid && cmd_ready && clk_ena) acc = 1;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (acc) cmd_valid = 1'b0;
      in_data = load_data[idx < 4 ? idx : 3];
    end
    check("pre_rst_writes", 32'(wr_log.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wren", 32'(ram_wren), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_writes", 32'(wr_log.size()), 32'd2);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
      check("rst_wr_addr", 32'(wr_log[i].a), 32'd10 + 32'(i));
      ref_mem[10 + i] = {ref_mem[10 + i][31:24], load_data[i][23:0]};
    end
    @(posedge clk); #1;
    run_xfer(0, 5'd8, 5'd13, 0, 100, 0);

    for (int t = 0; t < 24; t++) begin
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin
        load_data.delete();
        for (int i = 0; i < 32; i++) load_data.push_back($urandom);
        run_xfer(1, 5'(f), 5'(l), 2, $urandom_range(30, 100), 0);
      end else begin
        run_xfer(0, 5'(f), 5'(l), 2, $urandom_range(30, 100), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
